// File: rtl/aes128_round_sequencer_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 engine.
package aes128_round_sequencer_pkg;

  localparam int AES_NR  = 10;
  localparam int RC_W    = 4;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  typedef logic [BLOCK_W-1:0] block_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as inverse (a^254) followed by the affine transform, instead of a ROM table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, t, inv;
    x2  = gf_mul(a, a);
    x3  = gf_mul(x2, a);
    x6  = gf_mul(x3, x3);
    x12 = gf_mul(x6, x6);
    t   = gf_mul(x12, x3);
    for (int unsigned i = 0; i < 4; i++) t = gf_mul(t, t);
    inv = gf_mul(gf_mul(t, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes128_round_sequencer_if.sv
// Plaintext-in / ciphertext-out handshake bundle of the AES-128 sequencer.
interface aes128_round_sequencer_if;
  import aes128_round_sequencer_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t plaintext;
  block_t key;
  logic   out_valid;
  logic   out_ready;
  block_t ciphertext;
  logic   busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/KeyGeneration.sv
// Derives round key rc from round key rc-1 (AES-128 key schedule step).
module KeyGeneration
  import aes128_round_sequencer_pkg::*;
(
  input  logic [RC_W-1:0] rc,
  input  block_t          key_in,
  output block_t          key_out
);
  logic [31:0] w3, t, n0, n1, n2, n3;

  always_comb begin
    w3 = key_in[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(rc), 24'h0};
    n0 = key_in[127:96] ^ t;
    n1 = key_in[95:64]  ^ n0;
    n2 = key_in[63:32]  ^ n1;
    n3 = key_in[31:0]   ^ n2;
    key_out = {n0, n1, n2, n3};
  end
endmodule

// File: rtl/Round.sv
// One full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey with key rc.
module Round
  import aes128_round_sequencer_pkg::*;
(
  input  logic [RC_W-1:0] rc,
  input  block_t          state_in,
  input  block_t          key_in,
  output block_t          state_out,
  output block_t          key_out
);
  block_t subbed, shifted, mixed;

  subbytes      u_sb (.data_in(state_in), .data_out(subbed));
  shiftrow      u_sr (.data_in(subbed),   .data_out(shifted));
  KeyGeneration u_kg (.rc(rc), .key_in(key_in), .key_out(key_out));

  always_comb begin
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
  end

  assign state_out = mixed ^ key_out;
endmodule

// File: rtl/aes_final_round.sv
// Last AES round: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
module aes_final_round
  import aes128_round_sequencer_pkg::*;
(
  input  logic [RC_W-1:0] rc,
  input  block_t          state_in,
  input  block_t          key_in,
  output block_t          state_out
);
  block_t subbed, shifted, round_key;

  subbytes      u_sb (.data_in(state_in), .data_out(subbed));
  shiftrow      u_sr (.data_in(subbed),   .data_out(shifted));
  KeyGeneration u_kg (.rc(rc), .key_in(key_in), .key_out(round_key));

  assign state_out = shifted ^ round_key;
endmodule

// File: rtl/shiftrow.sv
// ShiftRows on a column-major state (byte 0 = bits [127:120]).
module shiftrow
  import aes128_round_sequencer_pkg::*;
(
  input  block_t data_in,
  output block_t data_out
);
  always_comb begin
    data_out = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        data_out[127-8*(4*c+r) -: 8] = data_in[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end
endmodule

// File: rtl/subbytes.sv
// Byte-wise S-box substitution over the whole 128-bit state.
module subbytes
  import aes128_round_sequencer_pkg::*;
(
  input  block_t data_in,
  output block_t data_out
);
  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < 16; i++) data_out[8*i +: 8] = sbox(data_in[8*i +: 8]);
  end
endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, ciphertext 10 clocks after accept.
module aes128_round_sequencer
  import aes128_round_sequencer_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int DATA_W = BLOCK_W
) (
  input logic                      clock,
  input logic                      reset_n,
  aes128_round_sequencer_if.slave  bus
);
  if (NR != AES_NR || DATA_W != BLOCK_W) begin : g_bad_cfg
    $error("aes128_round_sequencer supports only NR=10 and DATA_W=128");
  end

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NR);

  fsm_e            fsm_q, fsm_d;
  logic [RC_W-1:0] rc_q, rc_d;
  block_t          state_q, state_d;
  block_t          key_q, key_d;
  block_t          round_state, round_key, final_state;

  Round u_round (
    .rc        (rc_q),
    .state_in  (state_q),
    .key_in    (key_q),
    .state_out (round_state),
    .key_out   (round_key)
  );

  aes_final_round u_final (
    .rc        (RC_LAST),
    .state_in  (state_q),
    .key_in    (key_q),
    .state_out (final_state)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= ST_IDLE;
      rc_q    <= '0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rc_q    <= rc_d;
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    state_d = state_q;
    key_d   = key_q;
    case (fsm_q)
      ST_IDLE: begin
        rc_d = '0;
        if (bus.in_valid) begin
          state_d = bus.plaintext ^ bus.key;
          key_d   = bus.key;
          rc_d    = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rc_q == RC_LAST) begin
          state_d = final_state;
          fsm_d   = ST_DONE;
        end else begin
          state_d = round_state;
          key_d   = round_key;
          rc_d    = rc_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          fsm_d = ST_IDLE;
          rc_d  = '0;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready   = (fsm_q == ST_IDLE);
  assign bus.out_valid  = (fsm_q == ST_DONE);
  assign bus.busy       = (fsm_q != ST_IDLE);
  assign bus.ciphertext = state_q;
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: byte-array AES reference plus a timing model checked every cycle.
module tb_aes128_round_sequencer;
  localparam int unsigned LAT = 10;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] E0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  aes128_round_sequencer_if bus();

  aes128_round_sequencer #(.NR(10), .DATA_W(128)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  logic [7:0]  sbox_t [256];

  // Reference: a block in flight for m_age edges; ciphertext visible from age LAT until consumed.
  bit           m_pending = 1'b0;
  int unsigned  m_age = 0;
  logic [127:0] m_ct = '0;
  int unsigned  m_done_n = 0;
  int unsigned  dut_done_n = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from the generator walk p *= 3, q /= 3 over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q ^= q << 1;
      q ^= q << 2;
      q ^= q << 4;
      if (q[7]) q ^= 8'h09;
      sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = mul2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int i = 0; i < 16; i++) s[i] = t[(i + 4*(i%4)) % 16];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
          s[4*c+3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) dut_done_n++;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pending = 1'b0;
      m_age = 0;
    end else if (m_pending) begin
      if (m_age >= LAT && bus.out_ready) begin
        m_pending = 1'b0;
        m_done_n++;
      end else begin
        m_age++;
      end
    end else if (bus.in_valid) begin
      m_pending = 1'b1;
      m_age = 0;
      m_ct = ref_encrypt(bus.plaintext, bus.key);
    end
  end

  always @(negedge clock) begin
    chk1("in_ready", bus.in_ready, !m_pending);
    chk1("out_valid", bus.out_valid, m_pending && (m_age >= LAT));
    chk1("busy", bus.busy, m_pending);
    if (m_pending && (m_age >= LAT)) chk128("ciphertext", bus.ciphertext, m_ct);
  end

  task automatic step(input bit scramble);
    @(negedge clock);
    if (scramble) begin
      bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      bus.key       = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_out_valid(input string name, input bit scramble);
    int unsigned n = 0;
    while (!bus.out_valid && n < 40) begin
      step(scramble);
      n++;
    end
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: out_valid got 0 after 40 clocks, want 1", name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc;
    int unsigned n;
    int unsigned t_ov [2];
    logic [127:0] ct_ov [2];

    build_sbox();
    chk128("model_sbox_00", {120'h0, sbox_t[8'h00]}, 128'h63);
    chk128("model_sbox_53", {120'h0, sbox_t[8'h53]}, 128'hed);
    chk128("model_vec_B", ref_encrypt(PT_B, KEY_B), CT_B);
    chk128("model_vec_C", ref_encrypt(PT_C, KEY_C), CT_C);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk1("reset_in_ready", bus.in_ready, 1'b1);
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_busy", bus.busy, 1'b0);
    chk128("reset_ciphertext", bus.ciphertext, '0);
    reset_n = 1'b1;

    // Vector B; inputs scrambled every cycle after the accept edge.
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.in_valid  = 1'b1;
    @(negedge clock);
    acc = cyc;
    chk128("state_after_E0", dut.state_q, E0_B);
    step(1'b1);
    chk128("state_after_E1", dut.state_q, E1_B);
    wait_out_valid("vec_B", 1'b1);
    chk_int("latency_B", int'(cyc - acc), int'(LAT));
    chk128("ct_B", bus.ciphertext, CT_B);

    // Stall in DONE with out_ready low while in_valid keeps toggling.
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk128("hold_ct", bus.ciphertext, CT_B);
      chk1("hold_in_ready", bus.in_ready, 1'b0);
      chk1("hold_out_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk1("release_in_ready", bus.in_ready, 1'b1);
    chk1("release_out_valid", bus.out_valid, 1'b0);

    // Vector C with out_ready already high at the final edge.
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    bus.in_valid  = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    wait_out_valid("vec_C", 1'b0);
    chk128("ct_C", bus.ciphertext, CT_C);
    @(negedge clock);

    // Back-to-back: each block costs LAT run edges, one DONE edge and one IDLE accept edge.
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.in_valid  = 1'b1;
    @(negedge clock);
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    n = 0;
    t_ov[0] = 0; t_ov[1] = 0;
    ct_ov[0] = '0; ct_ov[1] = '0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        t_ov[n]  = cyc;
        ct_ov[n] = bus.ciphertext;
        n++;
        if (n == 2) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk_int("b2b_count", int'(n), 2);
    chk128("b2b_ct_first", ct_ov[0], CT_B);
    chk128("b2b_ct_second", ct_ov[1], CT_C);
    chk_int("b2b_spacing", int'(t_ov[1] - t_ov[0]), int'(LAT + 2));

    // Asynchronous reset in the middle of a block.
    @(negedge clock);
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.in_valid  = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk_int("rc_before_reset", int'(dut.rc_q), 5);
    #2 reset_n = 1'b0;
    #1;
    chk1("midreset_out_valid", bus.out_valid, 1'b0);
    chk1("midreset_in_ready", bus.in_ready, 1'b1);
    chk1("midreset_busy", bus.busy, 1'b0);
    chk128("midreset_ciphertext", bus.ciphertext, '0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    bus.in_valid  = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    wait_out_valid("vec_C_after_reset", 1'b0);
    chk128("ct_C_after_reset", bus.ciphertext, CT_C);
    @(negedge clock);

    // Random traffic with random back-pressure, checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      bus.key       = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid  = ($urandom % 3) != 0;
      bus.out_ready = ($urandom % 4) != 0;
    end
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (15) @(negedge clock);
    chk_int("completions", int'(dut_done_n), int'(m_done_n));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
